// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared widths and state encoding for the burst scheduler
package mem_sched_pkg;

    // Default bus widths of the display memory subsystem
    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_ADDR_BITS = 24;
    localparam int DEF_LEN_BITS  = 10;

    // State encoding
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_GRANT = 3'd1;
    localparam logic [2:0] S_WR_RUN   = 3'd2;
    localparam logic [2:0] S_RD_GRANT = 3'd3;
    localparam logic [2:0] S_RD_RUN   = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = S_IDLE,
        WR_GRANT = S_WR_GRANT,
        WR_RUN   = S_WR_RUN,
        RD_GRANT = S_RD_GRANT,
        RD_RUN   = S_RD_RUN,
        DONE     = S_DONE
    } sched_state_t;

endpackage

// File: rtl/mem_sched_watchdog.sv
// rtl/mem_sched_watchdog.sv - burst watchdog counter with clear, enable and expiry flag
module mem_sched_watchdog #(
    parameter int CNT_BITS = 16
) (
    input  logic                mem_clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [CNT_BITS-1:0] limit,
    output logic                expired
);

    logic [CNT_BITS-1:0] count;

    // Count enabled cycles since the last clear; saturate instead of wrapping
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Expired during the limit-th enabled cycle after a clear
    always_comb begin
        expired = en && ((count + 1'b1) == limit);
    end

endmodule

// File: rtl/mem_rw_sched.sv
// rtl/mem_rw_sched.sv - read-priority scheduler sharing the SDRAM burst port
module mem_rw_sched
    import mem_sched_pkg::*;
#(
    parameter int MEM_DATA_BITS = DEF_DATA_BITS,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int LEN_BITS      = DEF_LEN_BITS,
    parameter int RD_MAX_WAIT   = 4,
    parameter int TIMEOUT       = 8000
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     wr_burst_req,
    input  logic [LEN_BITS-1:0]      wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,
    input  logic                     rd_burst_req,
    input  logic [LEN_BITS-1:0]      rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish,
    output logic                     ctl_burst_req,
    output logic                     ctl_burst_wr,
    output logic [LEN_BITS-1:0]      ctl_burst_len,
    output logic [ADDR_BITS-1:0]     ctl_burst_addr,
    input  logic                     ctl_wr_data_req,
    output logic [MEM_DATA_BITS-1:0] ctl_wr_data,
    input  logic                     ctl_rd_data_valid,
    input  logic [MEM_DATA_BITS-1:0] ctl_rd_data,
    input  logic                     ctl_burst_finish,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam logic [3:0]  MAX_WAIT_L = 4'(RD_MAX_WAIT);
    localparam logic [15:0] TIMEOUT_L  = 16'(TIMEOUT);

    sched_state_t state, state_nxt;
    logic [3:0]   starve_cnt;
    logic         aborted;
    logic         wr_pend, rd_pend;
    logic         wd_clr, wd_en, wd_expired;

    assign wr_pend = wr_burst_req && (wr_burst_len != '0);
    assign rd_pend = rd_burst_req && (rd_burst_len != '0);

    mem_sched_watchdog #(
        .CNT_BITS (16)
    ) u_watchdog (
        .mem_clk (mem_clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .limit   (TIMEOUT_L),
        .expired (wd_expired)
    );

    // State register
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, burst sequencing and watchdog control
    always_comb begin
        state_nxt = state;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (rd_pend && wr_pend) begin
                    state_nxt = (starve_cnt >= MAX_WAIT_L) ? WR_GRANT : RD_GRANT;
                end else if (rd_pend) begin
                    state_nxt = RD_GRANT;
                end else if (wr_pend) begin
                    state_nxt = WR_GRANT;
                end
            end
            WR_GRANT: begin
                wd_clr    = 1'b1;
                state_nxt = WR_RUN;
            end
            RD_GRANT: begin
                wd_clr    = 1'b1;
                state_nxt = RD_RUN;
            end
            WR_RUN, RD_RUN: begin
                wd_en = 1'b1;
                if (ctl_burst_finish || wd_expired) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered burst command; request drops after the first data handshake
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            ctl_burst_req  <= 1'b0;
            ctl_burst_wr   <= 1'b0;
            ctl_burst_len  <= '0;
            ctl_burst_addr <= '0;
            aborted        <= 1'b0;
        end else begin
            case (state)
                WR_GRANT: begin
                    ctl_burst_req  <= 1'b1;
                    ctl_burst_wr   <= 1'b1;
                    ctl_burst_len  <= wr_burst_len;
                    ctl_burst_addr <= wr_burst_addr;
                    aborted        <= 1'b0;
                end
                RD_GRANT: begin
                    ctl_burst_req  <= 1'b1;
                    ctl_burst_wr   <= 1'b0;
                    ctl_burst_len  <= rd_burst_len;
                    ctl_burst_addr <= rd_burst_addr;
                    aborted        <= 1'b0;
                end
                WR_RUN, RD_RUN: begin
                    if (state_nxt == DONE) begin
                        ctl_burst_req <= 1'b0;
                        // A finish coincident with expiry is a normal completion
                        aborted       <= !ctl_burst_finish;
                    end else if ((state == WR_RUN && ctl_wr_data_req) ||
                                 (state == RD_RUN && ctl_rd_data_valid)) begin
                        ctl_burst_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Starvation counter: reads granted over a waiting write
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (state_nxt == WR_GRANT) begin
                starve_cnt <= '0;
            end else if (state_nxt == RD_GRANT && wr_pend && starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Data routing and status strobes decoded from state
    always_comb begin
        wr_burst_data_req   = ctl_wr_data_req && (state == WR_RUN);
        ctl_wr_data         = (state == WR_RUN) ? wr_burst_data : '0;
        rd_burst_data       = ctl_rd_data;
        rd_burst_data_valid = ctl_rd_data_valid && (state == RD_RUN);
        wr_burst_finish     = (state == DONE) && ctl_burst_wr;
        rd_burst_finish     = (state == DONE) && !ctl_burst_wr;
        timeout_err         = (state == DONE) && aborted;
        busy                = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_rw_sched.sv
// tb/tb_mem_rw_sched.sv - directed self-checking bench for mem_rw_sched
module tb_mem_rw_sched;

    logic        mem_clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_burst_req = 1'b0;
    logic [9:0]  wr_burst_len = '0;
    logic [23:0] wr_burst_addr = '0;
    logic        wr_burst_data_req;
    logic [31:0] wr_burst_data = '0;
    logic        wr_burst_finish;
    logic        rd_burst_req = 1'b0;
    logic [9:0]  rd_burst_len = '0;
    logic [23:0] rd_burst_addr = '0;
    logic        rd_burst_data_valid;
    logic [31:0] rd_burst_data;
    logic        rd_burst_finish;
    logic        ctl_burst_req;
    logic        ctl_burst_wr;
    logic [9:0]  ctl_burst_len;
    logic [23:0] ctl_burst_addr;
    logic        ctl_wr_data_req = 1'b0;
    logic [31:0] ctl_wr_data;
    logic        ctl_rd_data_valid = 1'b0;
    logic [31:0] ctl_rd_data = '0;
    logic        ctl_burst_finish = 1'b0;
    logic        busy;
    logic        timeout_err;

    int          checks = 0;
    int          errors = 0;
    int          pulses;
    int          early;
    bit          ok;
    logic [9:0]  order;

    always #5 mem_clk = ~mem_clk;

    mem_rw_sched #(
        .MEM_DATA_BITS (32),
        .ADDR_BITS     (24),
        .LEN_BITS      (10),
        .RD_MAX_WAIT   (4),
        .TIMEOUT       (100)
    ) dut (
        .mem_clk             (mem_clk),
        .rst                 (rst),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .ctl_burst_req       (ctl_burst_req),
        .ctl_burst_wr        (ctl_burst_wr),
        .ctl_burst_len       (ctl_burst_len),
        .ctl_burst_addr      (ctl_burst_addr),
        .ctl_wr_data_req     (ctl_wr_data_req),
        .ctl_wr_data         (ctl_wr_data),
        .ctl_rd_data_valid   (ctl_rd_data_valid),
        .ctl_rd_data         (ctl_rd_data),
        .ctl_burst_finish    (ctl_burst_finish),
        .busy                (busy),
        .timeout_err         (timeout_err)
    );

    task automatic next();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ctl_burst_req) begin
                seen = 1'b1;
                break;
            end
            next();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no summary expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset state
        next();
        next();
        checks++; if (busy !== 1'b0) fail("rst_busy", busy, 1'b0);
        checks++; if (ctl_burst_req !== 1'b0) fail("rst_ctl_req", ctl_burst_req, 1'b0);
        checks++; if (ctl_burst_len !== 10'd0) fail("rst_ctl_len", ctl_burst_len, 10'd0);
        checks++; if ((wr_burst_finish | rd_burst_finish | timeout_err) !== 1'b0) fail("rst_strobes", wr_burst_finish | rd_burst_finish | timeout_err, 1'b0);
        rst = 1'b0;
        next();

        // Write only, len 16 at 0x000100
        wr_burst_req  = 1'b1;
        wr_burst_len  = 10'd16;
        wr_burst_addr = 24'h000100;
        next();
        checks++; if (busy !== 1'b1) fail("wr_grant_busy", busy, 1'b1);
        checks++; if (ctl_burst_req !== 1'b0) fail("wr_grant_no_req", ctl_burst_req, 1'b0);
        next();
        checks++; if (ctl_burst_req !== 1'b1) fail("wr_cmd_req", ctl_burst_req, 1'b1);
        checks++; if (ctl_burst_wr !== 1'b1) fail("wr_cmd_wr", ctl_burst_wr, 1'b1);
        checks++; if (ctl_burst_len !== 10'd16) fail("wr_cmd_len", ctl_burst_len, 10'd16);
        checks++; if (ctl_burst_addr !== 24'h000100) fail("wr_cmd_addr", ctl_burst_addr, 24'h000100);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            ctl_wr_data_req = 1'b1;
            wr_burst_data   = 32'hD000_0000 + 32'(i);
            #1;
            if (wr_burst_data_req) pulses++;
            checks++; if (ctl_wr_data !== 32'hD000_0000 + 32'(i)) fail("wr_data_route", ctl_wr_data, 32'hD000_0000 + 32'(i));
            next();
            if (i == 0) begin
                checks++; if (ctl_burst_req !== 1'b0) fail("wr_req_drop", ctl_burst_req, 1'b0);
            end
        end
        ctl_wr_data_req = 1'b0;
        #1;
        checks++; if (wr_burst_data_req !== 1'b0) fail("wr_data_req_idle", wr_burst_data_req, 1'b0);
        checks++; if (pulses !== 16) fail("wr_pulse_count", pulses, 16);
        ctl_burst_finish = 1'b1;
        #1;
        checks++; if (wr_burst_finish !== 1'b0) fail("wr_fin_not_early", wr_burst_finish, 1'b0);
        next();
        ctl_burst_finish = 1'b0;
        checks++; if (wr_burst_finish !== 1'b1) fail("wr_fin_pulse", wr_burst_finish, 1'b1);
        checks++; if (rd_burst_finish !== 1'b0) fail("wr_fin_no_rd", rd_burst_finish, 1'b0);
        checks++; if (timeout_err !== 1'b0) fail("wr_fin_no_to", timeout_err, 1'b0);
        ctl_wr_data_req = 1'b1;
        #1;
        checks++; if (wr_burst_data_req !== 1'b0) fail("wr_strobe_dropped", wr_burst_data_req, 1'b0);
        checks++; if (ctl_wr_data !== 32'h0) fail("wr_data_zero_done", ctl_wr_data, 32'h0);
        ctl_wr_data_req = 1'b0;
        wr_burst_req    = 1'b0;
        next();
        checks++; if (wr_burst_finish !== 1'b0) fail("wr_fin_one_cycle", wr_burst_finish, 1'b0);
        checks++; if (busy !== 1'b0) fail("wr_idle_busy", busy, 1'b0);

        // Read only, len 8 at 0x000200
        rd_burst_req  = 1'b1;
        rd_burst_len  = 10'd8;
        rd_burst_addr = 24'h000200;
        next();
        next();
        checks++; if (ctl_burst_req !== 1'b1) fail("rd_cmd_req", ctl_burst_req, 1'b1);
        checks++; if (ctl_burst_wr !== 1'b0) fail("rd_cmd_wr", ctl_burst_wr, 1'b0);
        checks++; if (ctl_burst_len !== 10'd8) fail("rd_cmd_len", ctl_burst_len, 10'd8);
        checks++; if (ctl_burst_addr !== 24'h000200) fail("rd_cmd_addr", ctl_burst_addr, 24'h000200);
        for (int i = 0; i < 8; i++) begin
            ctl_rd_data_valid = 1'b1;
            ctl_rd_data       = 32'hA500_0000 + 32'(i * 3);
            #1;
            checks++; if (rd_burst_data_valid !== 1'b1) fail("rd_valid", rd_burst_data_valid, 1'b1);
            checks++; if (rd_burst_data !== 32'hA500_0000 + 32'(i * 3)) fail("rd_data", rd_burst_data, 32'hA500_0000 + 32'(i * 3));
            next();
        end
        ctl_rd_data_valid = 1'b0;
        ctl_burst_finish  = 1'b1;
        next();
        ctl_burst_finish = 1'b0;
        checks++; if (rd_burst_finish !== 1'b1) fail("rd_fin_pulse", rd_burst_finish, 1'b1);
        checks++; if (wr_burst_finish !== 1'b0) fail("rd_fin_no_wr", wr_burst_finish, 1'b0);
        ctl_rd_data_valid = 1'b1;
        #1;
        checks++; if (rd_burst_data_valid !== 1'b0) fail("rd_strobe_dropped", rd_burst_data_valid, 1'b0);
        ctl_rd_data_valid = 1'b0;
        rd_burst_req      = 1'b0;
        next();
        checks++; if (busy !== 1'b0) fail("rd_idle_busy", busy, 1'b0);
        checks++; if (rd_burst_finish !== 1'b0) fail("rd_fin_one_cycle", rd_burst_finish, 1'b0);

        // Both held continuously: starvation forces every fifth grant to write
        wr_burst_req  = 1'b1;
        wr_burst_len  = 10'd2;
        wr_burst_addr = 24'h000A00;
        rd_burst_req  = 1'b1;
        rd_burst_len  = 10'd2;
        rd_burst_addr = 24'h000B00;
        order = '0;
        for (int b = 0; b < 10; b++) begin
            wait_req(ok);
            checks++; if (ok !== 1'b1) fail("arb_grant_seen", ok, 1'b1);
            order[b] = ctl_burst_wr;
            ctl_burst_finish = 1'b1;
            next();
            ctl_burst_finish = 1'b0;
            if (b == 9) begin
                wr_burst_req = 1'b0;
                rd_burst_req = 1'b0;
            end
        end
        checks++; if (order !== 10'b10_0001_0000) fail("arb_grant_order", order, 10'b10_0001_0000);
        next();
        next();
        checks++; if (busy !== 1'b0) fail("arb_idle_busy", busy, 1'b0);

        // Controller never finishes: watchdog aborts 100 cycles into RUN
        wr_burst_req  = 1'b1;
        wr_burst_len  = 10'd4;
        wr_burst_addr = 24'h000300;
        wait_req(ok);
        checks++; if (ok !== 1'b1) fail("to_grant_seen", ok, 1'b1);
        rd_burst_req  = 1'b1;
        rd_burst_len  = 10'd4;
        rd_burst_addr = 24'h000400;
        early = 0;
        for (int i = 0; i < 99; i++) begin
            next();
            if (timeout_err || !busy || !ctl_burst_req || wr_burst_finish) early++;
        end
        checks++; if (early !== 0) fail("to_not_early", early, 0);
        next();
        checks++; if (timeout_err !== 1'b1) fail("to_err_pulse", timeout_err, 1'b1);
        checks++; if (wr_burst_finish !== 1'b1) fail("to_wr_finish", wr_burst_finish, 1'b1);
        checks++; if (ctl_burst_req !== 1'b0) fail("to_req_low", ctl_burst_req, 1'b0);
        wr_burst_req = 1'b0;
        next();
        checks++; if (timeout_err !== 1'b0) fail("to_err_one_cycle", timeout_err, 1'b0);
        next();
        next();
        checks++; if (ctl_burst_req !== 1'b1) fail("to_next_req", ctl_burst_req, 1'b1);
        checks++; if (ctl_burst_wr !== 1'b0) fail("to_next_is_rd", ctl_burst_wr, 1'b0);
        checks++; if (ctl_burst_addr !== 24'h000400) fail("to_next_addr", ctl_burst_addr, 24'h000400);
        ctl_burst_finish = 1'b1;
        next();
        ctl_burst_finish = 1'b0;
        checks++; if (rd_burst_finish !== 1'b1) fail("to_rd_finish", rd_burst_finish, 1'b1);
        checks++; if (timeout_err !== 1'b0) fail("to_rd_no_err", timeout_err, 1'b0);
        rd_burst_req = 1'b0;
        next();

        // Zero-length write is never granted; the read is
        wr_burst_req  = 1'b1;
        wr_burst_len  = 10'd0;
        wr_burst_addr = 24'h000700;
        rd_burst_req  = 1'b1;
        rd_burst_len  = 10'd4;
        rd_burst_addr = 24'h000500;
        next();
        next();
        checks++; if (ctl_burst_req !== 1'b1) fail("len0_req", ctl_burst_req, 1'b1);
        checks++; if (ctl_burst_wr !== 1'b0) fail("len0_is_rd", ctl_burst_wr, 1'b0);
        checks++; if (ctl_burst_addr !== 24'h000500) fail("len0_addr", ctl_burst_addr, 24'h000500);
        ctl_burst_finish = 1'b1;
        next();
        ctl_burst_finish = 1'b0;
        checks++; if (rd_burst_finish !== 1'b1) fail("len0_rd_finish", rd_burst_finish, 1'b1);
        rd_burst_req = 1'b0;
        early = 0;
        for (int i = 0; i < 6; i++) begin
            next();
            if (busy || ctl_burst_req) early++;
        end
        checks++; if (early !== 0) fail("len0_never_granted", early, 0);
        wr_burst_req = 1'b0;

        // Reset in the middle of a write burst
        wr_burst_req  = 1'b1;
        wr_burst_len  = 10'd8;
        wr_burst_addr = 24'h000600;
        next();
        next();
        checks++; if (ctl_burst_req !== 1'b1) fail("mid_rst_run_req", ctl_burst_req, 1'b1);
        ctl_wr_data_req = 1'b1;
        wr_burst_data   = 32'h1234_5678;
        next();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) fail("mid_rst_busy", busy, 1'b0);
        checks++; if (ctl_burst_req !== 1'b0) fail("mid_rst_req", ctl_burst_req, 1'b0);
        checks++; if (ctl_burst_wr !== 1'b0) fail("mid_rst_wr", ctl_burst_wr, 1'b0);
        checks++; if (ctl_burst_len !== 10'd0) fail("mid_rst_len", ctl_burst_len, 10'd0);
        checks++; if (ctl_burst_addr !== 24'h0) fail("mid_rst_addr", ctl_burst_addr, 24'h0);
        checks++; if (wr_burst_data_req !== 1'b0) fail("mid_rst_data_req", wr_burst_data_req, 1'b0);
        checks++; if (ctl_wr_data !== 32'h0) fail("mid_rst_wr_data", ctl_wr_data, 32'h0);
        ctl_wr_data_req = 1'b0;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            next();
            if (wr_burst_finish || rd_burst_finish || timeout_err || busy) early++;
        end
        checks++; if (early !== 0) fail("mid_rst_no_finish", early, 0);
        rst = 1'b0;
        next();
        checks++; if (busy !== 1'b1) fail("post_rst_grant", busy, 1'b1);
        next();
        checks++; if (ctl_burst_req !== 1'b1) fail("post_rst_req", ctl_burst_req, 1'b1);
        checks++; if (ctl_burst_len !== 10'd8) fail("post_rst_len", ctl_burst_len, 10'd8);
        checks++; if (ctl_burst_wr !== 1'b1) fail("post_rst_wr", ctl_burst_wr, 1'b1);
        ctl_burst_finish = 1'b1;
        next();
        ctl_burst_finish = 1'b0;
        checks++; if (wr_burst_finish !== 1'b1) fail("post_rst_finish", wr_burst_finish, 1'b1);
        wr_burst_req = 1'b0;
        next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
